// File: rtl/as2650_uart_if.sv
// Byte-wide CPU I/O bus between the AS2650 core and its UART.
// Single-cycle read/write strobes; read data is registered in the UART.
interface as2650_uart_if;
  logic [1:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;

  modport master (
    output bus_addr, bus_wdata, bus_we, bus_re,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_re,
    output bus_rdata
  );
endinterface

// File: rtl/as2650_uart.sv
// 8N1 UART with small TX/RX FIFOs on the AS2650 I/O bus.
// Four byte registers: DATA, STATUS/CTRL, DIVL, DIVH.
module as2650_uart #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  as2650_uart_if.slave bus,
  input  logic         uart_rx,
  output logic         uart_tx,
  output logic         irq
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;

  logic [15:0] r_div;
  logic        r_ie_rx, r_ie_tx;
  logic        r_ovr, r_fe, r_irq;
  logic [7:0]  r_rdata;

  logic [7:0]  r_txq [FIFO_DEPTH];
  logic [AW:0] r_txw, r_txr;
  logic [7:0]  r_rxq [FIFO_DEPTH];
  logic [AW:0] r_rxw, r_rxr;

  state_t      r_tx_st, w_tx_st_n;
  logic [15:0] r_tx_cnt, w_tx_cnt_n, r_tx_div;
  logic [7:0]  r_tx_sh, w_tx_sh_n;
  logic [2:0]  r_tx_bit, w_tx_bit_n;
  logic        r_tx_out, w_txd_n;
  logic        w_tx_pop, w_tx_load;

  logic        r_rx_s1, r_rx_s2, r_rx_s3;
  state_t      r_rx_st, w_rx_st_n;
  logic [15:0] r_rx_cnt, w_rx_cnt_n, r_rx_div;
  logic [7:0]  r_rx_sh, w_rx_sh_n;
  logic [2:0]  r_rx_bit, w_rx_bit_n;
  logic        w_rx_latch, w_rx_push_req, w_fe_set;

  logic        w_wr, w_rd, w_st_rd;
  logic        w_tx_empty, w_tx_full, w_tx_push;
  logic        w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;
  logic        w_rx_ovr, w_tx_end, w_rx_end;
  logic [15:0] w_div_eff, w_rx_half;
  logic [7:0]  w_status, w_tx_head, w_rx_head;

  assign w_wr    = bus.bus_we;
  assign w_rd    = bus.bus_re & ~bus.bus_we;
  assign w_st_rd = w_rd & (bus.bus_addr == 2'd1);

  assign w_tx_empty = r_txw == r_txr;
  assign w_tx_full  = (r_txw[AW] != r_txr[AW]) &&
                      (r_txw[AW-1:0] == r_txr[AW-1:0]);
  assign w_rx_empty = r_rxw == r_rxr;
  assign w_rx_full  = (r_rxw[AW] != r_rxr[AW]) &&
                      (r_rxw[AW-1:0] == r_rxr[AW-1:0]);
  assign w_tx_head  = r_txq[r_txr[AW-1:0]];
  assign w_rx_head  = r_rxq[r_rxr[AW-1:0]];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_tx_push = w_wr & (bus.bus_addr == 2'd0) &
                     (~w_tx_full | w_tx_pop);
  assign w_rx_pop  = w_rd & (bus.bus_addr == 2'd0) & ~w_rx_empty;
  assign w_rx_push = w_rx_push_req & (~w_rx_full | w_rx_pop);
  assign w_rx_ovr  = w_rx_push_req & w_rx_full & ~w_rx_pop;

  assign w_div_eff = (r_div < 16'd3) ? 16'd3 : r_div;
  assign w_rx_half = 16'(({1'b0, r_rx_div} + 17'd1) >> 1);
  assign w_tx_end  = r_tx_cnt == r_tx_div;
  assign w_rx_end  = r_rx_cnt == r_rx_div;

  assign w_status = {r_ie_tx, r_ie_rx, 1'b0, r_fe, r_ovr,
                     w_tx_empty & (r_tx_st == S_IDLE),
                     ~w_tx_full, ~w_rx_empty};

  assign bus.bus_rdata = r_rdata;
  assign uart_tx       = r_tx_out;
  assign irq           = r_irq;

  always_comb begin
    w_tx_st_n  = r_tx_st;
    w_tx_cnt_n = r_tx_cnt + 16'd1;
    w_tx_sh_n  = r_tx_sh;
    w_tx_bit_n = r_tx_bit;
    w_tx_pop   = 1'b0;
    w_tx_load  = 1'b0;
    unique case (r_tx_st)
      S_IDLE: begin
        w_tx_cnt_n = 16'd0;
        if (!w_tx_empty) begin
          w_tx_st_n = S_START;
          w_tx_pop  = 1'b1;
          w_tx_load = 1'b1;
        end
      end
      S_START: begin
        if (w_tx_end) begin
          w_tx_st_n  = S_DATA;
          w_tx_cnt_n = 16'd0;
          w_tx_bit_n = 3'd0;
        end
      end
      S_DATA: begin
        if (w_tx_end) begin
          w_tx_cnt_n = 16'd0;
          w_tx_sh_n  = {1'b0, r_tx_sh[7:1]};
          w_tx_bit_n = r_tx_bit + 3'd1;
          if (r_tx_bit == 3'd7) w_tx_st_n = S_STOP;
        end
      end
      default: begin
        if (w_tx_end) begin
          w_tx_cnt_n = 16'd0;
          if (!w_tx_empty) begin
            w_tx_st_n = S_START;
            w_tx_pop  = 1'b1;
            w_tx_load = 1'b1;
          end else begin
            w_tx_st_n = S_IDLE;
          end
        end
      end
    endcase
    if (w_tx_load) w_tx_sh_n = w_tx_head;
    unique case (w_tx_st_n)
      S_START: w_txd_n = 1'b0;
      S_DATA:  w_txd_n = w_tx_sh_n[0];
      default: w_txd_n = 1'b1;
    endcase
  end

  always_comb begin
    w_rx_st_n     = r_rx_st;
    w_rx_cnt_n    = r_rx_cnt + 16'd1;
    w_rx_sh_n     = r_rx_sh;
    w_rx_bit_n    = r_rx_bit;
    w_rx_latch    = 1'b0;
    w_rx_push_req = 1'b0;
    w_fe_set      = 1'b0;
    unique case (r_rx_st)
      S_IDLE: begin
        w_rx_cnt_n = 16'd0;
        if (!r_rx_s2 && r_rx_s3) begin
          w_rx_st_n  = S_START;
          w_rx_latch = 1'b1;
        end
      end
      S_START: begin
        // Mid-start re-check rejects glitches shorter than half a bit
        if (r_rx_cnt == w_rx_half - 16'd1) begin
          w_rx_cnt_n = 16'd0;
          w_rx_bit_n = 3'd0;
          w_rx_st_n  = r_rx_s2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_rx_end) begin
          w_rx_cnt_n = 16'd0;
          w_rx_sh_n  = {r_rx_s2, r_rx_sh[7:1]};
          w_rx_bit_n = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) w_rx_st_n = S_STOP;
        end
      end
      default: begin
        if (w_rx_end) begin
          w_rx_st_n     = S_IDLE;
          w_rx_push_req = 1'b1;
          w_fe_set      = ~r_rx_s2;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_tx_push) r_txq[r_txw[AW-1:0]] <= bus.bus_wdata;
    if (w_rx_push) r_rxq[r_rxw[AW-1:0]] <= r_rx_sh;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_tx_st  <= S_IDLE;
      r_tx_cnt <= 16'd0;
      r_tx_div <= DEFAULT_DIV;
      r_tx_sh  <= 8'd0;
      r_tx_bit <= 3'd0;
      r_tx_out <= 1'b1;
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_s3  <= 1'b1;
      r_rx_st  <= S_IDLE;
      r_rx_cnt <= 16'd0;
      r_rx_div <= DEFAULT_DIV;
      r_rx_sh  <= 8'd0;
      r_rx_bit <= 3'd0;
    end else begin
      r_tx_st  <= w_tx_st_n;
      r_tx_cnt <= w_tx_cnt_n;
      r_tx_sh  <= w_tx_sh_n;
      r_tx_bit <= w_tx_bit_n;
      r_tx_out <= w_txd_n;
      if (w_tx_load) r_tx_div <= w_div_eff;
      r_rx_s1  <= uart_rx;
      r_rx_s2  <= r_rx_s1;
      r_rx_s3  <= r_rx_s2;
      r_rx_st  <= w_rx_st_n;
      r_rx_cnt <= w_rx_cnt_n;
      r_rx_sh  <= w_rx_sh_n;
      r_rx_bit <= w_rx_bit_n;
      if (w_rx_latch) r_rx_div <= w_div_eff;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_txw   <= '0;
      r_txr   <= '0;
      r_rxw   <= '0;
      r_rxr   <= '0;
      r_div   <= DEFAULT_DIV;
      r_ie_rx <= 1'b0;
      r_ie_tx <= 1'b0;
      r_ovr   <= 1'b0;
      r_fe    <= 1'b0;
      r_irq   <= 1'b0;
      r_rdata <= 8'd0;
    end else begin
      if (w_tx_push) r_txw <= r_txw + 1'b1;
      if (w_tx_pop)  r_txr <= r_txr + 1'b1;
      if (w_rx_push) r_rxw <= r_rxw + 1'b1;
      if (w_rx_pop)  r_rxr <= r_rxr + 1'b1;
      if (w_wr) begin
        case (bus.bus_addr)
          2'd1: begin
            r_ie_rx <= bus.bus_wdata[6];
            r_ie_tx <= bus.bus_wdata[7];
          end
          2'd2:    r_div[7:0]  <= bus.bus_wdata;
          2'd3:    r_div[15:8] <= bus.bus_wdata;
          default: ;
        endcase
      end
      if (w_rd) begin
        case (bus.bus_addr)
          2'd0:    r_rdata <= w_rx_empty ? 8'd0 : w_rx_head;
          2'd1:    r_rdata <= w_status;
          2'd2:    r_rdata <= r_div[7:0];
          default: r_rdata <= r_div[15:8];
        endcase
      end
      // Reading STATUS clears the sticky flags unless a new event lands
      if (w_st_rd)       r_ovr <= w_rx_ovr;
      else if (w_rx_ovr) r_ovr <= 1'b1;
      if (w_st_rd)       r_fe  <= w_fe_set;
      else if (w_fe_set) r_fe  <= 1'b1;
      r_irq <= (r_ie_rx & ~w_rx_empty) | (r_ie_tx & w_tx_empty);
    end
  end
endmodule

// File: tb/tb_as2650_uart.sv
// Randomised bench for as2650_uart against a frame-level model
// of the register file, FIFOs and serial timing.
module tb_as2650_uart;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx, irq_o;

  as2650_uart_if u_if ();

  as2650_uart #(
    .FIFO_DEPTH (DEPTH),
    .DEFAULT_DIV(16'd433)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (u_if.slave),
    .uart_rx (rx),
    .uart_tx (tx),
    .irq     (irq_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [7:0]  m_txq[$];
  logic [7:0]  m_rxq[$];
  logic [15:0] m_div;
  bit          m_ie_rx, m_ie_tx, m_ovr, m_fe, m_busy;
  int          m_t, m_d;
  logic [7:0]  m_byte, m_rdata;
  logic        m_tx, m_irq;
  bit          chk_en  = 0;
  bit          rx_busy = 0;

  // Serial line level for a frame: slot 0 start, 1..8 data LSB first, 9 stop
  function automatic logic frame_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  function automatic void model_rx(input logic [7:0] b, input logic stp);
    if (m_rxq.size() == DEPTH) m_ovr = 1;
    else m_rxq.push_back(b);
    if (!stp) m_fe = 1;
  endfunction

  always @(posedge clk) begin
    logic [7:0] st;
    bit nirq;
    if (rst) begin
      m_txq.delete();
      m_rxq.delete();
      m_div = 16'd433;
      {m_ie_rx, m_ie_tx, m_ovr, m_fe, m_busy} = '0;
      m_t = 0;
      m_d = 433;
      m_tx = 1'b1;
      m_irq = 1'b0;
      m_rdata = 8'd0;
    end else begin
      nirq = (m_ie_rx && m_rxq.size() > 0) || (m_ie_tx && m_txq.size() == 0);
      st = {m_ie_tx, m_ie_rx, 1'b0, m_fe, m_ovr,
            (m_txq.size() == 0 && !m_busy),
            m_txq.size() < DEPTH, m_rxq.size() > 0};
      if (m_busy) begin
        m_t++;
        if (m_t == 10 * (m_d + 1)) m_busy = 0;
      end
      if (!m_busy && m_txq.size() > 0) begin
        m_byte = m_txq.pop_front();
        m_busy = 1;
        m_t = 0;
        m_d = (m_div < 16'd3) ? 3 : int'(m_div);
      end
      if (u_if.bus_we) begin
        case (u_if.bus_addr)
          2'd0: if (m_txq.size() < DEPTH) m_txq.push_back(u_if.bus_wdata);
          2'd1: begin
            m_ie_rx = u_if.bus_wdata[6];
            m_ie_tx = u_if.bus_wdata[7];
          end
          2'd2: m_div[7:0] = u_if.bus_wdata;
          default: m_div[15:8] = u_if.bus_wdata;
        endcase
      end else if (u_if.bus_re) begin
        case (u_if.bus_addr)
          2'd0: m_rdata = (m_rxq.size() > 0) ? m_rxq.pop_front() : 8'd0;
          2'd1: begin
            m_rdata = st;
            m_ovr = 0;
            m_fe = 0;
          end
          2'd2: m_rdata = m_div[7:0];
          default: m_rdata = m_div[15:8];
        endcase
      end
      m_irq = nirq;
      m_tx = m_busy ? frame_bit(m_byte, m_t / (m_d + 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_line", tx, m_tx);
      check("rdata", u_if.bus_rdata, m_rdata);
      if (!rx_busy) check("irq", irq_o, m_irq);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    u_if.bus_addr  = a;
    u_if.bus_wdata = d;
    u_if.bus_we    = 1'b1;
    idle(1);
    u_if.bus_we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    u_if.bus_addr = a;
    u_if.bus_re   = 1'b1;
    idle(1);
    u_if.bus_re   = 1'b0;
    d = u_if.bus_rdata;
  endtask

  task automatic send(input logic [7:0] b, input logic stp, input int per);
    rx_busy = 1;
    rx = 1'b0;
    idle(per);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(per);
    end
    rx = stp;
    idle(per);
    rx = 1'b1;
    model_rx(b, stp);
    idle(2);
    rx_busy = 0;
  endtask

  logic [7:0] d;
  logic [7:0] ov[5];
  logic [9:0] pat;
  int per;

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    u_if.bus_addr  = 2'd0;
    u_if.bus_wdata = 8'd0;
    u_if.bus_we    = 1'b0;
    u_if.bus_re    = 1'b0;
    @(posedge clk);
    chk_en = 1;
    idle(3);
    rst = 1'b0;
    check("rst_tx", tx, 1);
    check("rst_irq", irq_o, 0);
    rd(1, d); check("rst_status", d, 8'h06);
    rd(2, d); check("rst_divl", d, 8'hB1);
    rd(3, d); check("rst_divh", d, 8'h01);

    wr(2, 8'd9);
    wr(3, 8'd0);
    per = 10;
    wr(0, 8'h55);
    pat = 10'b1010101010;
    idle(1);
    for (int b = 0; b < 10; b++) begin
      idle(5);
      check($sformatf("tx55_slot%0d", b), tx, pat[b]);
      idle(5);
    end
    rd(1, d); check("txidle_after", d[2], 1);

    send(8'hA3, 1'b1, 10);
    rd(1, d); check("rxne_set", d[0], 1);
    rd(0, d); check("rx_a3", d, 8'hA3);
    rd(1, d); check("rxne_clr", d[0], 0);

    for (int i = 0; i < 5; i++) begin
      ov[i] = 8'($urandom);
      send(ov[i], 1'b1, 10);
    end
    rd(1, d); check("ovr_set", d[3], 1);
    for (int i = 0; i < 4; i++) begin
      rd(0, d); check($sformatf("ovr_byte%0d", i), d, ov[i]);
    end
    rd(1, d); check("ovr_clr", d[3], 0);

    send(8'h3C, 1'b0, 10);
    rd(1, d); check("fe_set", d[4], 1);
    rd(0, d); check("fe_byte", d, 8'h3C);

    rx_busy = 1;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(30);
    rx_busy = 0;
    rd(1, d); check("glitch_rxne", d[0], 0);

    wr(1, 8'h40);
    send(8'h5A, 1'b1, 10);
    idle(1);
    check("irq_rx_set", irq_o, 1);
    rd(0, d); check("irq_byte", d, 8'h5A);
    idle(1);
    check("irq_rx_clr", irq_o, 0);

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 6))
        0: begin
          int n = $urandom_range(1, 6);
          for (int k = 0; k < n; k++) wr(0, 8'($urandom));
        end
        1: begin
          int v = $urandom_range(0, 12);
          wr(2, 8'(v));
          wr(3, 8'd0);
          per = ((v < 3) ? 3 : v) + 1;
        end
        2: send(8'($urandom), ($urandom_range(0, 5) != 0), per);
        3: rd(2'($urandom_range(0, 3)), d);
        4: wr(1, 8'($urandom));
        5: idle($urandom_range(1, 40));
        default: begin
          u_if.bus_addr  = 2'($urandom_range(0, 3));
          u_if.bus_wdata = 8'($urandom);
          u_if.bus_we    = 1'b1;
          u_if.bus_re    = 1'b1;
          idle(1);
          u_if.bus_we    = 1'b0;
          u_if.bus_re    = 1'b0;
          if (u_if.bus_addr == 2'd2 || u_if.bus_addr == 2'd3) begin
            wr(2, 8'd9);
            wr(3, 8'd0);
            per = 10;
          end
        end
      endcase
    end

    wr(2, 8'd9);
    wr(3, 8'd0);
    per = 10;
    for (int k = 0; k < 3; k++) wr(0, 8'($urandom));
    idle(30);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("rst_mid_tx", tx, 1);
    rd(1, d); check("rst_mid_status", d, 8'h06);
    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
